fineps_ctrl: RTL
================

Name: fineps_ctrl

Overview:
- Responder for the fine-phase-shift command interface (in_fineps_incr/decr/valid, out_fineps_dready).
- Accepts one step command at a time and translates it into a single MMCM dynamic-phase-shift transaction (PSEN pulse, PSINCDEC, wait for PSDONE).
- Tracks the net signed phase position in steps and flags PSDONE timeouts.
- Sits inside the clock-generation wrapper, clocked by the same clock as the MMCM PSCLK.

Parameters:
- INT_STEPS_WRAP, 504, phase steps per full output-clock period (56 x VCO/out divide); the position counter wraps modulo this value.
- INT_POS_WIDTH, 10, width of out_fineps_pos; must satisfy 2^INT_POS_WIDTH > INT_STEPS_WRAP.
- INT_PSDONE_TIMEOUT, 64, maximum cycles waited for in_psdone after the PSEN pulse.

Ports:
- in_fineps_clk  in  1  clock (same clock as MMCM PSCLK).
- in_fineps_rst_n  in  1  reset, asynchronous, active-low.
- in_fineps_incr  in  1  request one increment step.
- in_fineps_decr  in  1  request one decrement step.
- in_fineps_valid  in  1  command qualifier; may be held constantly high.
- out_fineps_dready  out  1  ready to accept a command.
- in_locked  in  1  MMCM locked.
- out_psen  out  1  MMCM PSEN.
- out_psincdec  out  1  MMCM PSINCDEC (1 = increment).
- in_psdone  in  1  MMCM PSDONE.
- out_fineps_pos  out  INT_POS_WIDTH  current phase position in steps, 0..INT_STEPS_WRAP-1.
- out_fineps_timeout  out  1  sticky PSDONE timeout flag.

Behaviour:
- Clocking and reset:
  - All state is clocked on in_fineps_clk.
  - Reset is asynchronous, active-low, on in_fineps_rst_n.
  - Reset values: out_fineps_dready=0, out_psen=0, out_psincdec=0, out_fineps_pos=0, out_fineps_timeout=0, FSM=S_LOCKWAIT.
- FSM states: S_LOCKWAIT, S_IDLE, S_PULSE, S_WAIT.
- S_LOCKWAIT:
  - dready=0.
  - Moves to S_IDLE on the first edge that samples in_locked=1.
- S_IDLE:
  - dready=1.
  - Command accepted when valid=1 AND dready=1 AND exactly one of incr/decr is 1.
  - incr=decr=1, or both 0, is a no-op: no PSEN, and dready stays 1.
  - On accept: register the direction and go to S_PULSE.
- S_PULSE:
  - out_psen=1 for exactly one cycle.
  - out_psincdec = registered direction; it is held stable from S_PULSE until the transaction completes.
  - dready=0.
  - Next state: S_WAIT.
- S_WAIT:
  - dready=0.
  - A timeout counter starts at 0.
  - On in_psdone=1: position += 1 (incr) or -= 1 (decr), modulo INT_STEPS_WRAP; go to S_IDLE.
  - If the counter reaches INT_PSDONE_TIMEOUT-1 without in_psdone: set out_fineps_timeout, leave position unchanged, go to S_IDLE.
- Latency, measured from the edge that accepts command edge N:
  - dready low and out_psen high, both registered, visible after edge N (cycle N+1).
  - PSDONE sampled at edge M: position update and dready=1 visible after edge M.
- Wrap rules:
  - Position 503 with incr → 0.
  - Position 0 with decr → 503.
- Lock loss:
  - in_locked=0 in any state → S_LOCKWAIT next edge.
  - Position is cleared to 0, because the MMCM relocks at its static phase.
  - A pending transaction is abandoned with no position update.
  - out_psen is forced to 0.
- Stray in_psdone outside S_WAIT is ignored.
- out_fineps_timeout is cleared only by reset.

Optional Feature:
- Macro: FINEPS_SAT_EN.
- With the macro defined:
  - Position saturates at the range ends instead of wrapping.
  - incr at INT_STEPS_WRAP-1, or decr at 0, is rejected: no PSEN is issued and dready stays 1.
- Without the macro: position wraps modulo INT_STEPS_WRAP as described above.

Test Plan:
- Release reset with in_locked=0 for 20 cycles, then assert it → dready stays 0 throughout, then reads 1 one cycle after locked is sampled; pos=0.
- valid held at 1, single-cycle incr pulse; MMCM model returns psdone 12 cycles after PSEN → psen high exactly 1 cycle with psincdec=1, dready low until psdone, pos=1.
- 504 incr steps then 504 decr steps, using the wait-for-dready handshake → pos reaches 503, wraps to 0, then 503 after the first decr, and finishes at 0. With FINEPS_SAT_EN: pos sticks at 503 with no psen on the extra incr, then returns to 0.
- incr=decr=1 with valid=1 → no psen; dready stays 1; pos unchanged.
- Model withholds psdone → timeout flag set on cycle 64 after PSEN, dready returns to 1, pos unchanged; a subsequent step completes normally and the flag stays 1.
- Deassert in_locked during S_WAIT at pos=7 → dready 0 and pos=0 on the next cycle; a late psdone is ignored; relock brings dready back to 1.

Source files
------------

// File: rtl/fineps_ctrl.sv
// Fine-phase-shift command responder: turns one incr/decr step into one MMCM PSEN/PSDONE transaction.
// Optional build macro FINEPS_SAT_EN: the position saturates at the range ends instead of wrapping.
module fineps_ctrl #(
    parameter int unsigned INT_STEPS_WRAP     = 504,
    parameter int unsigned INT_POS_WIDTH      = 10,
    parameter int unsigned INT_PSDONE_TIMEOUT = 64
) (
    input  logic                     in_fineps_clk,
    input  logic                     in_fineps_rst_n,
    input  logic                     in_fineps_incr,
    input  logic                     in_fineps_decr,
    input  logic                     in_fineps_valid,
    output logic                     out_fineps_dready,
    input  logic                     in_locked,
    output logic                     out_psen,
    output logic                     out_psincdec,
    input  logic                     in_psdone,
    output logic [INT_POS_WIDTH-1:0] out_fineps_pos,
    output logic                     out_fineps_timeout
);

    localparam int unsigned CNT_W = (INT_PSDONE_TIMEOUT > 1) ? $clog2(INT_PSDONE_TIMEOUT) : 1;
    localparam logic [INT_POS_WIDTH-1:0] POS_MAX  = INT_POS_WIDTH'(INT_STEPS_WRAP - 1);
    localparam logic [CNT_W-1:0]         CNT_LAST = CNT_W'(INT_PSDONE_TIMEOUT - 1);

    localparam logic [1:0] S_LOCKWAIT = 2'd0;
    localparam logic [1:0] S_IDLE     = 2'd1;
    localparam logic [1:0] S_PULSE    = 2'd2;
    localparam logic [1:0] S_WAIT     = 2'd3;

    logic [1:0]               state_q;
    logic [1:0]               state_nxt;
    logic [CNT_W-1:0]         cnt_q;
    logic [CNT_W-1:0]         cnt_nxt;
    logic [INT_POS_WIDTH-1:0] pos_nxt;
    logic [INT_POS_WIDTH-1:0] pos_step;
    logic                     dir_nxt;
    logic                     timeout_nxt;
    logic                     blocked;

    // Next position if the pending step completes
    always_comb begin
        pos_step = out_fineps_pos;
        if (out_psincdec) begin
            pos_step = (out_fineps_pos == POS_MAX) ? '0 : out_fineps_pos + 1'b1;
        end else begin
            pos_step = (out_fineps_pos == '0) ? POS_MAX : out_fineps_pos - 1'b1;
        end
    end

    // Steps that would run past a range end are refused in saturating builds
    always_comb begin
        blocked = 1'b0;
`ifdef FINEPS_SAT_EN
        blocked = (in_fineps_incr && (out_fineps_pos == POS_MAX)) ||
                  (in_fineps_decr && (out_fineps_pos == '0));
`else
        blocked = 1'b0;
`endif
    end

    // Next-state and datapath decode; lock loss overrides everything
    always_comb begin
        state_nxt   = state_q;
        cnt_nxt     = cnt_q;
        pos_nxt     = out_fineps_pos;
        dir_nxt     = out_psincdec;
        timeout_nxt = out_fineps_timeout;
        if (!in_locked) begin
            state_nxt = S_LOCKWAIT;
            pos_nxt   = '0;
        end else begin
            case (state_q)
                S_LOCKWAIT: state_nxt = S_IDLE;
                S_IDLE: begin
                    if (in_fineps_valid && out_fineps_dready &&
                        (in_fineps_incr ^ in_fineps_decr) && !blocked) begin
                        dir_nxt   = in_fineps_incr;
                        cnt_nxt   = '0;
                        state_nxt = S_PULSE;
                    end
                end
                S_PULSE: begin
                    cnt_nxt   = cnt_q + 1'b1;
                    state_nxt = S_WAIT;
                end
                S_WAIT: begin
                    if (in_psdone) begin
                        pos_nxt   = pos_step;
                        state_nxt = S_IDLE;
                    end else if (cnt_q == CNT_LAST) begin
                        timeout_nxt = 1'b1;
                        state_nxt   = S_IDLE;
                    end else begin
                        cnt_nxt = cnt_q + 1'b1;
                    end
                end
                default: state_nxt = S_LOCKWAIT;
            endcase
        end
    end

    // State and registered outputs; dready/psen are decoded from the next state
    always_ff @(posedge in_fineps_clk or negedge in_fineps_rst_n) begin
        if (!in_fineps_rst_n) begin
            state_q            <= S_LOCKWAIT;
            cnt_q              <= '0;
            out_fineps_dready  <= 1'b0;
            out_psen           <= 1'b0;
            out_psincdec       <= 1'b0;
            out_fineps_pos     <= '0;
            out_fineps_timeout <= 1'b0;
        end else begin
            state_q            <= state_nxt;
            cnt_q              <= cnt_nxt;
            out_fineps_dready  <= (state_nxt == S_IDLE);
            out_psen           <= (state_nxt == S_PULSE);
            out_psincdec       <= dir_nxt;
            out_fineps_pos     <= pos_nxt;
            out_fineps_timeout <= timeout_nxt;
        end
    end

endmodule
